// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache: single-cycle hits, whole-line fill/writeback.
// Latency: hit 0 cycles (combinational rdata); miss = detect + [writeback] + fill + hit cycle.
// Backpressure: CacheStall holds the pipeline while a miss is serviced; mem_ready completes each line transfer.
module data_cache #(
    parameter int NUM_LINES  = 4,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     we,
    input  logic                     byte_en,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     CacheStall,
    output logic                     mem_rd_req,
    output logic                     mem_wr_req,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_WORDS*32-1:0] mem_wdata,
    input  logic [LINE_WORDS*32-1:0] mem_rdata,
    input  logic                     mem_ready
);
    localparam int LINE_W = LINE_WORDS * 32;
    localparam int IW     = $clog2(NUM_LINES);
    localparam int TW     = ADDR_W - 4 - IW;

    typedef enum logic [1:0] {IDLE, WBACK, FILL} state_t;

    state_t                state_q, state_d;
    logic [NUM_LINES-1:0]  valid_q, dirty_q;
    logic [TW-1:0]         tag_q  [NUM_LINES];
    logic [LINE_W-1:0]     data_q [NUM_LINES];
    logic [ADDR_W-5:0]     fill_line_q;

    logic [IW-1:0]         idx, fill_idx;
    logic [TW-1:0]         tag, fill_tag;
    logic [LINE_W-1:0]     line, store_line;
    logic [31:0]           word;
    logic [7:0]            byte_sel;
    logic                  hit, miss, victim_dirty, store_hit;

    assign idx          = addr[4+IW-1:4];
    assign tag          = addr[ADDR_W-1:4+IW];
    assign line         = data_q[idx];
    assign word         = line[{addr[3:2], 5'b0} +: 32];
    assign byte_sel     = word[{addr[1:0], 3'b0} +: 8];
    assign hit          = req & valid_q[idx] & (tag_q[idx] == tag);
    assign miss         = req & ~hit;
    assign victim_dirty = valid_q[idx] & dirty_q[idx];
    assign store_hit    = (state_q == IDLE) & hit & we;

    // The fill target is latched at detect time so a dropped req cannot redirect the install.
    assign fill_idx     = fill_line_q[IW-1:0];
    assign fill_tag     = fill_line_q[ADDR_W-5:IW];

    assign mem_rd_req   = (state_q == FILL);
    assign mem_wr_req   = (state_q == WBACK);
    assign CacheStall   = rst & ((state_q != IDLE) | miss);

    always_comb begin
        rdata = '0;
        if (rst && state_q == IDLE && hit && !we) begin
            rdata = byte_en ? {24'b0, byte_sel} : word;
        end
    end

    always_comb begin
        store_line = line;
        if (byte_en) begin
            store_line[{addr[3:0], 3'b0} +: 8] = wdata[7:0];
        end else begin
            store_line[{addr[3:2], 5'b0} +: 32] = wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss) state_d = victim_dirty ? WBACK : FILL;
            WBACK:   if (mem_ready) state_d = FILL;
            FILL:    if (mem_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            fill_line_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        fill_line_q <= addr[ADDR_W-1:4];
                        if (victim_dirty) begin
                            mem_addr  <= {tag_q[idx], idx, 4'b0};
                            mem_wdata <= line;
                        end else begin
                            mem_addr  <= {addr[ADDR_W-1:4], 4'b0};
                        end
                    end else if (store_hit) begin
                        dirty_q[idx] <= 1'b1;
                    end
                end
                WBACK: begin
                    if (mem_ready) begin
                        dirty_q[fill_idx] <= 1'b0;
                        mem_addr          <= {fill_line_q, 4'b0};
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        valid_q[fill_idx] <= 1'b1;
                        dirty_q[fill_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data and tag arrays carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (state_q == FILL && mem_ready) begin
            data_q[fill_idx] <= mem_rdata;
            tag_q[fill_idx]  <= fill_tag;
        end else if (store_hit) begin
            data_q[idx] <= store_line;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache: flat reference memory plus a line-residency model, with a memory responder.
module tb_data_cache;
    logic         clk = 1'b0;
    logic         rst;
    logic         req, we, byte_en;
    logic [31:0]  addr, wdata, rdata, mem_addr;
    logic         CacheStall, mem_rd_req, mem_wr_req, mem_ready;
    logic [127:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    data_cache #(.NUM_LINES(4), .LINE_WORDS(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .byte_en(byte_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .CacheStall(CacheStall),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int tests = 0;
    int fails = 0;

    // backing = contents of main memory; ref_mem = what the program should observe
    logic [31:0] backing [int];
    logic [31:0] ref_mem [int];
    bit          mvalid [4];
    bit          mdirty [4];
    int          mtag   [4];

    int          fix_lat = 0;
    int          last_fill_lat, last_wb_lat;
    bit          saw_wr, saw_rd;
    logic [31:0] first_wr_addr, first_wr_d0, first_rd_addr, last_rdata;
    int          last_lat;
    bit          last_stall_first;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] back_rd(input int wa);
        return backing.exists(wa) ? backing[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] ref_rd(input int wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    function automatic logic [127:0] ref_line(input logic [31:0] a);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[32*w +: 32] = ref_rd(int'(a >> 2) + w);
        return l;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic b);
        logic [31:0] wv;
        wv = ref_rd(int'(a >> 2));
        if (b) return (wv >> (8 * a[1:0])) & 32'hFF;
        return wv;
    endfunction

    task automatic sync_ref();
        ref_mem.delete();
        foreach (backing[k]) ref_mem[k] = backing[k];
    endtask

    // Memory responder: pulses mem_ready after a latency, serving/absorbing whole lines.
    initial begin : responder
        int cnt;
        int cur_lat;
        cnt = 0;
        cur_lat = 1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (!rst || !(mem_rd_req || mem_wr_req)) begin
                cnt = 0;
            end else begin
                if (cnt == 0) cur_lat = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 6));
                cnt++;
                if (cnt >= cur_lat) begin
                    mem_ready = 1'b1;
                    cnt = 0;
                    if (mem_wr_req) begin
                        last_wb_lat = cur_lat;
                        for (int w = 0; w < 4; w++) backing[int'(mem_addr >> 2) + w] = mem_wdata[32*w +: 32];
                    end else begin
                        last_fill_lat = cur_lat;
                        for (int w = 0; w < 4; w++) mem_rdata[32*w +: 32] = back_rd(int'(mem_addr >> 2) + w);
                    end
                end
            end
        end
    end

    // Per-cycle compare against the reference memory.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("one_req", mem_rd_req & mem_wr_req, 1'b0);
            if (mem_rd_req || mem_wr_req) chk("line_align", mem_addr[3:0], 4'h0);
            if (mem_wr_req) begin
                chk("wb_data", mem_wdata, ref_line(mem_addr));
                if (!saw_wr) begin
                    first_wr_addr = mem_addr;
                    first_wr_d0   = mem_wdata[31:0];
                end
                saw_wr = 1'b1;
            end
            if (mem_rd_req) begin
                if (!saw_rd) first_rd_addr = mem_addr;
                saw_rd = 1'b1;
                chk("fill_addr", mem_addr, {addr[31:4], 4'h0});
            end
            if (req && !CacheStall && !we) chk("load_data", rdata, exp_load(addr, byte_en));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the access completes.
    task automatic do_access(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d);
        int  li, cyc;
        bit  exp_hit, exp_wb;
        logic [31:0] wv;
        li      = int'((a >> 4) & 32'h3);
        exp_hit = mvalid[li] && (mtag[li] == int'(a >> 6));
        exp_wb  = !exp_hit && mvalid[li] && mdirty[li];
        saw_wr  = 1'b0;
        saw_rd  = 1'b0;
        req = 1'b1; we = w; byte_en = b; addr = a; wdata = d;
        @(negedge clk);
        last_stall_first = CacheStall;
        chk("stall_first", CacheStall, !exp_hit);
        cyc = 0;
        if (!exp_hit) begin
            while (CacheStall === 1'b1 && cyc < 300) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 300) begin
                tests++; fails++;
                $display("FAIL miss_timeout: stall still high after %0d cycles, required to drop", cyc);
            end
            chk("saw_wb", saw_wr, exp_wb);
            chk("saw_fill", saw_rd, 1'b1);
            chk("miss_lat", cyc, last_fill_lat + 1 + (exp_wb ? last_wb_lat : 0));
            mvalid[li] = 1'b1;
            mtag[li]   = int'(a >> 6);
            mdirty[li] = 1'b0;
        end
        last_lat   = cyc;
        last_rdata = rdata;
        if (w) begin
            wv = ref_rd(int'(a >> 2));
            if (b) wv[8*a[1:0] +: 8] = d[7:0];
            else   wv = d;
            ref_mem[int'(a >> 2)] = wv;
            mdirty[li] = 1'b1;
        end
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int wait_cyc;
        logic [31:0] ra;
        logic rw, rb;
        rst = 1'b0; req = 1'b0; we = 1'b0; byte_en = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < 4; i++) begin mvalid[i] = 0; mdirty[i] = 0; mtag[i] = 0; end
        backing[32'h40 >> 2] = 32'h1111_2222;
        backing[32'h44 >> 2] = 32'h3333_4444;
        sync_ref();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", CacheStall, 1'b0);
        chk("rst_rd_req", mem_rd_req, 1'b0);
        chk("rst_wr_req", mem_wr_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        fix_lat = 5;
        do_access(1'b0, 1'b0, 32'h40, 32'h0);
        chk("lit_fill_addr", first_rd_addr, 32'h40);
        chk("lit_miss_lat", last_lat, 6);
        chk("lit_load40", last_rdata, 32'h1111_2222);
        do_access(1'b0, 1'b0, 32'h44, 32'h0);
        chk("lit_hit44_stall", last_stall_first, 1'b0);
        chk("lit_load44", last_rdata, 32'h3333_4444);
        do_access(1'b1, 1'b1, 32'h42, 32'hFFFF_FFAB);
        do_access(1'b0, 1'b0, 32'h40, 32'h0);
        chk("lit_word40", last_rdata, 32'h11AB_2222);
        do_access(1'b0, 1'b1, 32'h42, 32'h0);
        chk("lit_byte42", last_rdata, 32'h0000_00AB);
        do_access(1'b0, 1'b0, 32'h80, 32'h0);
        chk("lit_wb_seen", saw_wr, 1'b1);
        chk("lit_wb_addr", first_wr_addr, 32'h40);
        chk("lit_wb_d0", first_wr_d0, 32'h11AB_2222);
        chk("lit_fill80", first_rd_addr, 32'h80);
        do_access(1'b1, 1'b0, 32'hC0, 32'hDEAD_BEEF);
        chk("lit_storemiss_wb", saw_wr, 1'b0);
        do_access(1'b0, 1'b0, 32'hC0, 32'h0);
        chk("lit_reloadC0", last_rdata, 32'hDEAD_BEEF);
        do_access(1'b0, 1'b0, 32'h00, 32'h0);
        chk("lit_evictC0_addr", first_wr_addr, 32'hC0);
        chk("lit_evictC0_d0", first_wr_d0, 32'hDEAD_BEEF);

        fix_lat = 0;
        for (int n = 0; n < 300; n++) begin
            rw = 1'($urandom_range(0, 1));
            rb = ($urandom_range(0, 3) == 0);
            ra = $urandom_range(0, 32'h3FF);
            if (!rb) ra[1:0] = 2'b00;
            do_access(rw, rb, ra, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("idle_stall", CacheStall, 1'b0);
                @(posedge clk);
                #1;
            end
        end

        // Reset while a fill is outstanding.
        fix_lat = 50;
        req = 1'b1; we = 1'b0; byte_en = 1'b0; addr = 32'h100;
        wait_cyc = 0;
        while (mem_rd_req !== 1'b1 && wait_cyc < 300) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("rstfill_reached", mem_rd_req, 1'b1);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rstfill_rd_req", mem_rd_req, 1'b0);
        chk("rstfill_stall", CacheStall, 1'b0);
        chk("rstfill_mem_addr", mem_addr, 32'h0);
        chk("rstfill_rdata", rdata, 32'h0);
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin mvalid[i] = 0; mdirty[i] = 0; end
        sync_ref();
        fix_lat = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_access(1'b0, 1'b0, 32'h40, 32'h0);
        chk("lit_post_rst_miss", last_stall_first, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
